mux16_1: RTL and testbench



---
 rtl/mux_pkg.sv | 6 +
 rtl/mux4_1.sv | 23 ++
 rtl/mux16_1.sv | 59 +++++
 tb/tb_mux16_1.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the datapath word multiplexers.
package mux_pkg;
  localparam int unsigned MUX_SEL_W  = 4;
  localparam int unsigned MUX_NUM_IN = 16;
  localparam int unsigned MUX_WIDTH  = 16;
endpackage

// File: rtl/mux4_1.sv
// Combinational 4:1 word selector; leaf stage of the 16:1 tree.
module mux4_1 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    unique case (s)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
    endcase
  end

endmodule

// File: rtl/mux16_1.sv
// Registered 16:1 word multiplexer built as a two-level tree of 4:1 stages.
module mux16_1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic [WIDTH-1:0]     in3,
  input  logic [WIDTH-1:0]     in4,
  input  logic [WIDTH-1:0]     in5,
  input  logic [WIDTH-1:0]     in6,
  input  logic [WIDTH-1:0]     in7,
  input  logic [WIDTH-1:0]     in8,
  input  logic [WIDTH-1:0]     in9,
  input  logic [WIDTH-1:0]     in10,
  input  logic [WIDTH-1:0]     in11,
  input  logic [WIDTH-1:0]     in12,
  input  logic [WIDTH-1:0]     in13,
  input  logic [WIDTH-1:0]     in14,
  input  logic [WIDTH-1:0]     in15,
  input  logic [MUX_SEL_W-1:0] sel,
  output logic [WIDTH-1:0]     out
);

  logic [WIDTH-1:0] mux1_y, mux2_y, mux3_y, mux4_y;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Level 1: low select bits pick within each group of four inputs.
  mux4_1 #(.WIDTH(WIDTH)) mux1 (
    .a(in0),  .b(in1),  .c(in2),  .d(in3),  .s(sel[1:0]), .y(mux1_y)
  );
  mux4_1 #(.WIDTH(WIDTH)) mux2 (
    .a(in4),  .b(in5),  .c(in6),  .d(in7),  .s(sel[1:0]), .y(mux2_y)
  );
  mux4_1 #(.WIDTH(WIDTH)) mux3 (
    .a(in8),  .b(in9),  .c(in10), .d(in11), .s(sel[1:0]), .y(mux3_y)
  );
  mux4_1 #(.WIDTH(WIDTH)) mux4 (
    .a(in12), .b(in13), .c(in14), .d(in15), .s(sel[1:0]), .y(mux4_y)
  );

  // Level 2: high select bits pick the group.
  mux4_1 #(.WIDTH(WIDTH)) mux_l2 (
    .a(mux1_y), .b(mux2_y), .c(mux3_y), .d(mux4_y), .s(sel[3:2]), .y(out_d)
  );

  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_mux16_1.sv
// Directed self-checking bench for the registered 16:1 word multiplexer.
module tb_mux16_1;

  typedef struct {
    logic        rst;
    logic [3:0]  sel;
    logic [15:0] exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] din [16];
  logic [3:0]  sel;
  logic [15:0] out;

  int unsigned n_checks;
  int unsigned n_fail;
  vec_t        vecs [$];

  mux16_1 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in0(din[0]),   .in1(din[1]),   .in2(din[2]),   .in3(din[3]),
    .in4(din[4]),   .in5(din[5]),   .in6(din[6]),   .in7(din[7]),
    .in8(din[8]),   .in9(din[9]),   .in10(din[10]), .in11(din[11]),
    .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
    .sel(sel), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_identity();
    for (int i = 0; i < 16; i++) din[i] = 16'(i);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    sel      = 4'h3;
    set_identity();

    // Reset hold, release, full sweep with wrap, mid-sweep reset, recovery.
    vecs.push_back('{1'b1, 4'h3, 16'h0000});
    vecs.push_back('{1'b1, 4'h3, 16'h0000});
    vecs.push_back('{1'b0, 4'h3, 16'h0003});
    for (int i = 0; i < 16; i++) vecs.push_back('{1'b0, 4'(i), 16'(i)});
    vecs.push_back('{1'b0, 4'h0, 16'h0000});
    vecs.push_back('{1'b0, 4'h1, 16'h0001});
    vecs.push_back('{1'b0, 4'h2, 16'h0002});
    vecs.push_back('{1'b1, 4'h3, 16'h0000});
    vecs.push_back('{1'b0, 4'h4, 16'h0004});
    vecs.push_back('{1'b0, 4'h5, 16'h0005});

    foreach (vecs[k]) begin
      reset = vecs[k].rst;
      sel   = vecs[k].sel;
      step();
      check($sformatf("vec%0d", k), out, vecs[k].exp);
    end
    reset = 1'b0;

    // Hold between edges and glitch invisibility.
    sel = 4'h9;
    step();
    check("pre_glitch", out, 16'h0009);
    #2 sel = 4'h1;
    #1 din[9] = 16'hDEAD;
    #1 din[9] = 16'h0009;
    #1 sel = 4'h9;
    check("hold_between_edges", out, 16'h0009);
    step();
    check("post_glitch", out, 16'h0009);

    // Bit integrity.
    for (int i = 0; i < 16; i++) din[i] = 16'hFFFF;
    din[5]  = 16'hA5A5;
    din[10] = 16'h5A5A;
    sel = 4'h5;
    step();
    check("bits_sel5", out, 16'hA5A5);
    sel = 4'hA;
    step();
    check("bits_sel10", out, 16'h5A5A);

    // Walking one through in15.
    sel = 4'hF;
    for (int b = 0; b < 16; b++) begin
      din[15] = 16'h0001 << b;
      step();
      check($sformatf("walk%0d", b), out, 16'h0001 << b);
    end

    // Unselected inputs toggling must not leak.
    sel    = 4'h7;
    din[7] = 16'h1234;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 16; i++)
        if (i != 7) din[i] = (c % 2 == 0) ? 16'hFFFF : 16'h0000;
      if (c == 5) din[3] = 16'hxxxx;
      step();
      check($sformatf("isolate%0d", c), out, 16'h1234);
    end

    // sel and the newly selected input change on the same cycle.
    set_identity();
    sel = 4'h2;
    step();
    check("same_edge_before", out, 16'h0002);
    sel     = 4'hC;
    din[12] = 16'hBEEF;
    step();
    check("same_edge_after", out, 16'hBEEF);

    // Reset wins over data; first deasserted edge loads.
    reset = 1'b1;
    step();
    check("reset_wins", out, 16'h0000);
    reset = 1'b0;
    step();
    check("reset_release", out, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
